// File: rtl/fp_operand_stage.sv
// Two-entry operand FIFO for a binary64 add/multiply pipeline: classifies operands on
// acceptance and flags special/invalid cases. Define FP_DENORM_FLUSH_EN to flush subnormals to signed zero.
module fp_operand_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_a,
    output logic [63:0] out_b,
    output logic        out_op,
    output logic [2:0]  out_cls_a,
    output logic [2:0]  out_cls_b,
    output logic        out_special,
    output logic        out_invalid,
    output logic        out_flushed
);

    localparam logic [2:0] CLS_NORM = 3'b000;
    localparam logic [2:0] CLS_ZERO = 3'b001;
    localparam logic [2:0] CLS_INF  = 3'b010;
    localparam logic [2:0] CLS_QNAN = 3'b011;
    localparam logic [2:0] CLS_SNAN = 3'b100;
    localparam logic [2:0] CLS_SUB  = 3'b101;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        op;
        logic [2:0]  cls_a;
        logic [2:0]  cls_b;
        logic        special;
        logic        invalid;
        logic        flushed;
    } entry_t;

    function automatic logic [2:0] classify(input logic [63:0] v);
        logic [2:0] c;
        if (v[62:52] == 11'd0)
            c = (v[51:0] == 52'd0) ? CLS_ZERO : CLS_SUB;
        else if (v[62:52] == 11'h7FF) begin
            if (v[51:0] == 52'd0)
                c = CLS_INF;
            else
                c = v[51] ? CLS_QNAN : CLS_SNAN;
        end else
            c = CLS_NORM;
        return c;
    endfunction

    entry_t     mem [0:1];
    entry_t     new_entry;
    entry_t     head;
    logic       wr_ptr, rd_ptr;
    logic [1:0] count, count_next;
    logic       ready_q;
    logic       push, pop;
    logic [2:0] ca, cb;
    logic       inf_a, inf_b, zero_a, zero_b;

    // Handshake: a transfer happens on a rising edge where valid && ready; in_ready is a
    // register so it never depends combinationally on out_ready.
    assign in_ready  = ready_q;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && ready_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        new_entry    = '0;
        new_entry.a  = in_a;
        new_entry.b  = in_b;
        new_entry.op = in_op;
        ca           = classify(in_a);
        cb           = classify(in_b);
`ifdef FP_DENORM_FLUSH_EN
        if (ca == CLS_SUB) begin
            new_entry.a       = {in_a[63], 63'd0};
            ca                = CLS_ZERO;
            new_entry.flushed = 1'b1;
        end
        if (cb == CLS_SUB) begin
            new_entry.b       = {in_b[63], 63'd0};
            cb                = CLS_ZERO;
            new_entry.flushed = 1'b1;
        end
`endif
        inf_a  = (ca == CLS_INF);
        inf_b  = (cb == CLS_INF);
        zero_a = (ca == CLS_ZERO);
        zero_b = (cb == CLS_ZERO);
        new_entry.cls_a   = ca;
        new_entry.cls_b   = cb;
        new_entry.special = inf_a || inf_b || (ca == CLS_QNAN) || (cb == CLS_QNAN)
                            || (ca == CLS_SNAN) || (cb == CLS_SNAN);
        // Invalid uses post-flush classes, so a flushed subnormal behaves as a true zero.
        new_entry.invalid = (ca == CLS_SNAN) || (cb == CLS_SNAN)
                            || (!in_op && inf_a && inf_b && (new_entry.a[63] != new_entry.b[63]))
                            || (in_op && ((inf_a && zero_b) || (zero_a && inf_b)));
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            ready_q <= 1'b0;
            mem[0]  <= '0;
            mem[1]  <= '0;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign head        = mem[rd_ptr];
    assign out_a       = head.a;
    assign out_b       = head.b;
    assign out_op      = head.op;
    assign out_cls_a   = head.cls_a;
    assign out_cls_b   = head.cls_b;
    assign out_special = head.special;
    assign out_invalid = head.invalid;
`ifdef FP_DENORM_FLUSH_EN
    assign out_flushed = head.flushed;
`else
    assign out_flushed = 1'b0;
`endif

endmodule
